// File: rtl/neuron_backprop_serial.sv
// Serial backward pass of one neuron: grad_w[i]=delta*a[i], grad_a[i]=delta*w[i], grad_b=delta.
// Define NEURON_BP_SAT_EN for saturating narrowing plus a sticky sat_flag output.
module neuron_backprop_serial #(
    parameter int INPUT_WIDTH = 3,
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BITS   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] a_in      [INPUT_WIDTH],
    input  logic signed [DATA_WIDTH-1:0] w_in      [INPUT_WIDTH],
    input  logic signed [DATA_WIDTH-1:0] delta_in,
    input  logic                         valid_in,
    output logic                         ready_in,
    output logic signed [DATA_WIDTH-1:0] grad_w    [INPUT_WIDTH],
    output logic signed [DATA_WIDTH-1:0] grad_a    [INPUT_WIDTH],
    output logic signed [DATA_WIDTH-1:0] grad_b,
    output logic                         valid_out,
    input  logic                         ready_out,
    output logic                         busy
`ifdef NEURON_BP_SAT_EN
    ,
    output logic                         sat_flag
`endif
);

    localparam int IDX_W = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_WIDTH - 1);
    localparam int PROD_W = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0]             index;
    logic signed [DATA_WIDTH-1:0] a_q [INPUT_WIDTH];
    logic signed [DATA_WIDTH-1:0] w_q [INPUT_WIDTH];
    logic signed [DATA_WIDTH-1:0] delta_q;

    logic signed [PROD_W-1:0]     prod_w, prod_a;
    logic signed [DATA_WIDTH-1:0] gw, ga;
    logic                         sat_any;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output is given a default first so this block cannot infer a latch.
    always_comb begin
        state_d   = state_q;
        ready_in  = 1'b0;
        valid_out = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                ready_in = 1'b1;
                if (valid_in) state_d = COMPUTE;
            end
            COMPUTE: begin
                busy = 1'b1;
                if (index == LAST_IDX) state_d = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                valid_out = 1'b1;
                if (ready_out) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the operand capture registers carry no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && valid_in) begin
            for (int i = 0; i < INPUT_WIDTH; i++) begin
                a_q[i] <= a_in[i];
                w_q[i] <= w_in[i];
            end
            delta_q <= delta_in;
        end
    end

    // Shared multiplier pair, full precision before the fixed-point shift.
    always_comb begin
        prod_w = PROD_W'(delta_q) * PROD_W'(a_q[index]);
        prod_a = PROD_W'(delta_q) * PROD_W'(w_q[index]);
    end

`ifdef NEURON_BP_SAT_EN
    function automatic logic signed [DATA_WIDTH-1:0] narrow(
        input  logic signed [PROD_W-1:0] prod,
        output logic                     sat
    );
        logic signed [PROD_W-1:0] shifted;
        shifted = prod >>> FRAC_BITS;
        // Any disagreement among the bits above the target sign bit means out of range.
        sat = (shifted[PROD_W-1:DATA_WIDTH-1] != {(DATA_WIDTH+1){shifted[PROD_W-1]}});
        if (!sat)
            narrow = shifted[DATA_WIDTH-1:0];
        else if (shifted[PROD_W-1])
            narrow = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            narrow = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    endfunction

    logic sat_w, sat_a;

    always_comb begin
        sat_w   = 1'b0;
        sat_a   = 1'b0;
        gw      = narrow(prod_w, sat_w);
        ga      = narrow(prod_a, sat_a);
        sat_any = sat_w | sat_a;
    end
`else
    always_comb begin
        gw      = DATA_WIDTH'(prod_w >>> FRAC_BITS);
        ga      = DATA_WIDTH'(prod_a >>> FRAC_BITS);
        sat_any = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            index  <= '0;
            grad_b <= '0;
            for (int i = 0; i < INPUT_WIDTH; i++) begin
                grad_w[i] <= '0;
                grad_a[i] <= '0;
            end
`ifdef NEURON_BP_SAT_EN
            sat_flag <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_in) begin
                        index <= '0;
`ifdef NEURON_BP_SAT_EN
                        sat_flag <= 1'b0;
`endif
                    end
                end
                COMPUTE: begin
                    grad_w[index] <= gw;
                    grad_a[index] <= ga;
                    if (index == '0) grad_b <= delta_q;
`ifdef NEURON_BP_SAT_EN
                    if (sat_any) sat_flag <= 1'b1;
`endif
                    // Hold at the last element so the counter never runs past the array.
                    if (index != LAST_IDX) index <= index + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifndef NEURON_BP_SAT_EN
    logic unused_sat;
    assign unused_sat = sat_any;
`endif

endmodule

// File: tb/tb_neuron_backprop_serial.sv
// Randomized self-checking bench for neuron_backprop_serial against an arithmetic reference model.
// Build with NEURON_BP_SAT_EN defined to exercise the saturating variant.
module tb_neuron_backprop_serial;

    localparam int N  = 3;
    localparam int DW = 16;
    localparam int FB = 8;

    logic clk = 1'b0;
    logic rst;
    logic signed [DW-1:0] a_in [N];
    logic signed [DW-1:0] w_in [N];
    logic signed [DW-1:0] delta_in;
    logic valid_in, ready_in, valid_out, ready_out, busy;
    logic signed [DW-1:0] grad_w [N];
    logic signed [DW-1:0] grad_a [N];
    logic signed [DW-1:0] grad_b;
`ifdef NEURON_BP_SAT_EN
    logic sat_flag;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    int stim_a [N];
    int stim_w [N];
    int stim_d;
    int exp_w [N];
    int exp_a [N];
    int exp_b;
    bit exp_sat;

    always #5 clk = ~clk;

    neuron_backprop_serial #(
        .INPUT_WIDTH(N),
        .DATA_WIDTH (DW),
        .FRAC_BITS  (FB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a_in     (a_in),
        .w_in     (w_in),
        .delta_in (delta_in),
        .valid_in (valid_in),
        .ready_in (ready_in),
        .grad_w   (grad_w),
        .grad_a   (grad_a),
        .grad_b   (grad_b),
        .valid_out(valid_out),
        .ready_out(ready_out),
        .busy     (busy)
`ifdef NEURON_BP_SAT_EN
        ,
        .sat_flag (sat_flag)
`endif
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: exact product, floor division by 2^FB, then saturate or wrap to DW bits.
    function automatic int model_grad(input int d, input int x, output bit sat);
        longint p, q, scale, span;
        scale = longint'(1) << FB;
        span  = longint'(1) << DW;
        p = longint'(d) * longint'(x);
        q = p / scale;
        if ((p % scale) != 0 && p < 0) q = q - 1;
        sat = 1'b0;
`ifdef NEURON_BP_SAT_EN
        if (q > span / 2 - 1) begin
            q = span / 2 - 1;
            sat = 1'b1;
        end else if (q < -(span / 2)) begin
            q = -(span / 2);
            sat = 1'b1;
        end
`else
        q = ((q % span) + span) % span;
        if (q >= span / 2) q = q - span;
`endif
        return int'(q);
    endfunction

    task automatic compute_expected();
        bit s;
        exp_sat = 1'b0;
        for (int i = 0; i < N; i++) begin
            exp_w[i] = model_grad(stim_d, stim_a[i], s);
            exp_sat  = exp_sat | s;
            exp_a[i] = model_grad(stim_d, stim_w[i], s);
            exp_sat  = exp_sat | s;
        end
        exp_b = stim_d;
    endtask

    task automatic drive_stim();
        for (int i = 0; i < N; i++) begin
            a_in[i] = DW'(stim_a[i]);
            w_in[i] = DW'(stim_w[i]);
        end
        delta_in = DW'(stim_d);
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < N; i++) begin
            a_in[i] = DW'($urandom);
            w_in[i] = DW'($urandom);
        end
        delta_in = DW'($urandom);
    endtask

    function automatic int rand_val(input bit full);
        if (full) return int'($urandom_range(0, 65535)) - 32768;
        return int'($urandom_range(0, 2047)) - 1024;
    endfunction

    task automatic check_outputs(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_gw%0d", tag, i), int'(grad_w[i]), exp_w[i]);
            check($sformatf("%s_ga%0d", tag, i), int'(grad_a[i]), exp_a[i]);
        end
        check($sformatf("%s_gb", tag), int'(grad_b), exp_b);
`ifdef NEURON_BP_SAT_EN
        check($sformatf("%s_sat", tag), int'(sat_flag), int'(exp_sat));
`endif
    endtask

    task automatic check_cleared(input string tag);
        check($sformatf("%s_ready_in", tag), int'(ready_in), 1);
        check($sformatf("%s_valid_out", tag), int'(valid_out), 0);
        check($sformatf("%s_busy", tag), int'(busy), 0);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_gw%0d", tag, i), int'(grad_w[i]), 0);
            check($sformatf("%s_ga%0d", tag, i), int'(grad_a[i]), 0);
        end
        check($sformatf("%s_gb", tag), int'(grad_b), 0);
`ifdef NEURON_BP_SAT_EN
        check($sformatf("%s_sat", tag), int'(sat_flag), 0);
`endif
    endtask

    // Starts and ends just after a falling edge; returns after the capture edge.
    task automatic send();
        int waited = 0;
        compute_expected();
        drive_stim();
        valid_in = 1'b1;
        while (!ready_in && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!ready_in) begin
            check("send_ready_timeout", int'(ready_in), 1);
            valid_in = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        scramble_inputs();
    endtask

    // Returns the edge number (capture = edge 0) at which the consumer first samples valid_out high.
    task automatic wait_valid(output int seen);
        seen = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid_out) begin
                seen = k + 1;
                break;
            end
        end
        if (seen < 0) check("valid_timeout", int'(valid_out), 1);
    endtask

    task automatic handshake();
        ready_out = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int lat, v1, v2, hold;
        bit drop;

        rst = 1'b1;
        valid_in = 1'b0;
        ready_out = 1'b1;
        for (int i = 0; i < N; i++) begin
            a_in[i] = '0;
            w_in[i] = '0;
        end
        delta_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_cleared("reset");

        // Basic bundle with the downstream always ready.
        stim_a = '{256, 512, -256};
        stim_w = '{128, -256, 768};
        stim_d = 512;
        send();
        wait_valid(lat);
        check("basic_latency", lat, N + 1);
        check_outputs("basic");
        check("basic_gw0_lit", int'(grad_w[0]), 512);
        check("basic_ga2_lit", int'(grad_a[2]), 1536);
        @(posedge clk);
        @(negedge clk);
        check("basic_valid_one_cycle", int'(valid_out), 0);
        check("basic_back_idle", int'(ready_in), 1);

        // Backpressure: results must hold and a new valid_in must be ignored.
        ready_out = 1'b0;
        send();
        wait_valid(lat);
        check_outputs("bp_first");
        for (int i = 0; i < N; i++) begin
            a_in[i] = DW'(rand_val(1'b1));
            w_in[i] = DW'(rand_val(1'b1));
        end
        delta_in = DW'(rand_val(1'b1));
        valid_in = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_valid_held", int'(valid_out), 1);
            check("bp_ready_in_low", int'(ready_in), 0);
            check("bp_busy", int'(busy), 1);
            check_outputs("bp_hold");
        end
        valid_in = 1'b0;
        handshake();
        check("bp_release_ready_in", int'(ready_in), 1);
        check("bp_release_valid_out", int'(valid_out), 0);
        check("bp_release_busy", int'(busy), 0);
        check_outputs("bp_not_captured");

        // Overflow on element 0.
        stim_a = '{32767, rand_val(1'b0), rand_val(1'b0)};
        stim_w = '{32767, rand_val(1'b0), rand_val(1'b0)};
        stim_d = 32767;
        send();
        wait_valid(lat);
        check_outputs("ovf");
`ifdef NEURON_BP_SAT_EN
        check("ovf_gw0_lit", int'(grad_w[0]), 32767);
        check("ovf_sat_lit", int'(sat_flag), 1);
`else
        check("ovf_gw0_lit", int'(grad_w[0]), -256);
`endif
        handshake();

        // Reset while the counter sits on element 1.
        for (int i = 0; i < N; i++) begin
            stim_a[i] = rand_val(1'b1);
            stim_w[i] = rand_val(1'b1);
        end
        stim_d = rand_val(1'b1);
        send();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_cleared("midrst");
        for (int i = 0; i < N; i++) begin
            stim_a[i] = rand_val(1'b0);
            stim_w[i] = rand_val(1'b0);
        end
        stim_d = rand_val(1'b0);
        send();
        wait_valid(lat);
        check_outputs("after_rst");
        handshake();

        // Back-to-back: second bundle held valid upstream while the first completes.
        stim_a = '{256, 512, -256};
        stim_w = '{128, -256, 768};
        stim_d = 512;
        send();
        delta_in = DW'(-256);
        for (int i = 0; i < N; i++) begin
            a_in[i] = DW'(stim_a[i]);
            w_in[i] = DW'(stim_w[i]);
        end
        valid_in = 1'b1;
        v1 = -1;
        v2 = -1;
        drop = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (drop) begin
                valid_in = 1'b0;
                drop = 1'b0;
            end
            if (valid_in && ready_in) drop = 1'b1;
            if (valid_out && v1 < 0) begin
                v1 = k;
                check_outputs("b2b_first");
                stim_d = -256;
                compute_expected();
            end else if (valid_out && v1 >= 0 && v2 < 0) begin
                v2 = k;
                check_outputs("b2b_second");
                check("b2b_gw2_lit", int'(grad_w[2]), 256);
                check("b2b_ga2_lit", int'(grad_a[2]), -768);
                break;
            end
        end
        valid_in = 1'b0;
        if (v1 < 0 || v2 < 0) check("b2b_timeout", int'(valid_out), 1);
        else check("b2b_spacing", v2 - v1, N + 2);
        handshake();

        // Zero delta with random operands.
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < N; i++) begin
                stim_a[i] = rand_val(1'b1);
                stim_w[i] = rand_val(1'b1);
            end
            stim_d = 0;
            send();
            wait_valid(lat);
            check_outputs("zero");
            handshake();
        end

        // Randomized bundles with random downstream stalls.
        for (int t = 0; t < 20; t++) begin
            bit full;
            full = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) begin
                stim_a[i] = rand_val(full);
                stim_w[i] = rand_val(full);
            end
            stim_d = rand_val(full);
            ready_out = $urandom_range(0, 1) == 1;
            send();
            wait_valid(lat);
            check("rand_latency", lat, N + 1);
            check_outputs("rand");
            hold = $urandom_range(0, 3);
            if (!ready_out) begin
                repeat (hold) begin
                    @(posedge clk);
                    @(negedge clk);
                    check("rand_hold_valid", int'(valid_out), 1);
                end
            end
            handshake();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
